vga_native_arbiter: RTL and testbench
=====================================

# vga_native_arbiter

Arbitrates two native-interface requesters onto one single-port, synchronous-read memory (the VGA framebuffer/register RAM). Port 0 is the AXI-Lite slave bridge (CPU accesses); port 1 is the pixel fetch engine (scanline reads). The block issues at most one access per cycle through a fixed 3-cycle pipeline and returns a tagged response to the originating port. Port 1 may burst up to `MAX_BURST` consecutive beats before port 0 must be served.

## Interface
- `ADDR_W`, 12, native word address width
- `DATA_W`, 32, data width
- `MAX_BURST`, 4, max consecutive port-1 grants while port 0 waits; must be ≥1
- `clk_i`  in  1  clock
- `arst_ni`  in  1  reset; synchronous, active-low (sampled on `clk_i` rising edge only)
- `reqN_valid_i`  in  1  request valid, N∈{0,1}
- `reqN_ready_o`  out  1  request accepted this cycle (combinational grant)
- `reqN_we_i`  in  1  1=write, 0=read
- `reqN_addr_i`  in  ADDR_W  word address
- `reqN_wdata_i`  in  DATA_W  write data
- `rspN_valid_o`  out  1  response pulse (read data or write ack)
- `rspN_rdata_o`  out  DATA_W  read data; 0 for write acks
- `mem_en_o`  out  1  memory access strobe
- `mem_we_o`  out  1  memory write enable
- `mem_addr_o`  out  ADDR_W  memory address
- `mem_wdata_o`  out  DATA_W  memory write data
- `mem_rdata_i`  in  DATA_W  read data, valid the cycle after `mem_en_o`
- `grant_cnt_o`  out  $clog2(MAX_BURST+1)  current burst counter (debug)

## Operation
- Accept on port N = `reqN_valid_i && reqN_ready_o`. At most one of `req0_ready_o`, `req1_ready_o` is high in any cycle; ready is never high without its own valid.
- Grant rule (combinational, from valids and `cnt`):
  - only one valid → that port granted;
  - both valid → port 1 iff `cnt < MAX_BURST`, else port 0;
  - none → no grant.
- Burst counter `cnt` (the arbitration state, width $clog2(MAX_BURST+1)):
  - port-0 accept → 0;
  - port-1 accept → min(cnt+1, MAX_BURST) (saturates, never wraps);
  - no accept → hold.
- Resulting fairness: with both continuously valid, the pattern is MAX_BURST port-1 beats then 1 port-0 beat, repeating. Port 0 waits at most MAX_BURST cycles once valid.
- Pipeline: stage 1 registers the accepted request into `mem_*` plus tag {port, we}; stage 2 delays the tag alongside the memory read latency; stage 3 registers `mem_rdata_i` (or 0 for writes) into `rspN_rdata_o` and pulses `rspN_valid_o` for the tagged port.
- Responses have no backpressure; requesters must sink them. Responses return in acceptance order.
- No write/read hazard handling is needed: single port, in-order issue, and the memory completes a write in its `mem_en_o` cycle.

## Timing
- Accept in cycle T → `mem_en_o`/`mem_we_o`/`mem_addr_o`/`mem_wdata_o` valid in T+1 → `mem_rdata_i` sampled at the end of T+2 → `rspN_valid_o`/`rspN_rdata_o` valid in T+3 for exactly one cycle.
- Throughput is one access per cycle; back-to-back accepts produce back-to-back `mem_en_o` and back-to-back responses.
- `mem_en_o` is 0 in cycles following a no-accept cycle. When `mem_en_o` is 0, `mem_we_o` is 0 and `mem_addr_o`/`mem_wdata_o` hold their previous values.
- Reset (`arst_ni` low at a clock edge):
  - the next cycle has `mem_en_o`, `mem_we_o`, `rsp*_valid_o` = 0, `mem_addr_o`, `mem_wdata_o`, `rsp*_rdata_o` = 0, `cnt` = 0, and all pipeline tags invalid;
  - `reqN_ready_o` is forced 0 while `arst_ni` is low;
  - in-flight accesses are dropped with no response. A write already presented on `mem_en_o` before the reset edge has completed; later pipeline stages are discarded.
- Simultaneous port-0 accept and port-1 valid: `cnt` clears to 0 at the next edge, so port 1 wins the next contested cycle.

## Test plan
- Reset: hold `arst_ni` low 3 cycles with both valids high → ready, `mem_en_o`, `rsp*_valid_o` all 0. Release → port 1 accepted first (cnt=0<4).
- Single read: port 0 read addr 0x010, memory model returns 0xDEADBEEF → `mem_en_o`=1, `mem_addr_o`=0x010 at T+1; `rsp0_valid_o`=1, `rsp0_rdata_o`=0xDEADBEEF at T+3; `rsp1_valid_o` stays 0.
- Write ack: port 1 writes 0xA5A5A5A5 to 0x0FF → `mem_we_o`=1, data on `mem_wdata_o` at T+1; `rsp1_valid_o`=1 with `rsp1_rdata_o`=0 at T+3.
- Contention, MAX_BURST=4, both valid for 15 cycles → accept sequence 1,1,1,1,0,1,1,1,1,0,1,1,1,1,0; `grant_cnt_o` goes 1,2,3,4,0,…; each response is routed to the correct port in order.
- Port 1 alone for 10 cycles → 10 accepts and `cnt` saturates at 4. Then port 0 asserts with port 1 still valid → port 0 accepted on its first valid cycle.
- Reset mid-flight: accept reads in cycles T and T+1, assert reset at the T+2 edge → no `rsp*_valid_o` pulses afterward, and `mem_en_o`=0 from T+3.

Source files
------------

// File: rtl/vga_native_arbiter.sv
// vga_native_arbiter: shares one single-port, synchronous-read memory between
// the CPU bridge (port 0) and the pixel fetch engine (port 1). Port 1 may take
// up to MAX_BURST consecutive grants while port 0 waits. Each accepted access
// runs through a fixed 3-stage pipeline, and a tagged response returns to the
// port that issued it.
module vga_native_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                               clk_i,
  input  logic                               arst_ni,

  input  logic                               req0_valid_i,
  output logic                               req0_ready_o,
  input  logic                               req0_we_i,
  input  logic [ADDR_W-1:0]                  req0_addr_i,
  input  logic [DATA_W-1:0]                  req0_wdata_i,
  output logic                               rsp0_valid_o,
  output logic [DATA_W-1:0]                  rsp0_rdata_o,

  input  logic                               req1_valid_i,
  output logic                               req1_ready_o,
  input  logic                               req1_we_i,
  input  logic [ADDR_W-1:0]                  req1_addr_i,
  input  logic [DATA_W-1:0]                  req1_wdata_i,
  output logic                               rsp1_valid_o,
  output logic [DATA_W-1:0]                  rsp1_rdata_o,

  output logic                               mem_en_o,
  output logic                               mem_we_o,
  output logic [ADDR_W-1:0]                  mem_addr_o,
  output logic [DATA_W-1:0]                  mem_wdata_o,
  input  logic [DATA_W-1:0]                  mem_rdata_i,

  output logic [$clog2(MAX_BURST+1)-1:0]     grant_cnt_o
);

  localparam int                CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BURST);

  // Burst counter increment that saturates at MAX_BURST instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] r;
    if (c >= CNT_MAX) r = CNT_MAX;
    else              r = c + 1'b1;
    return r;
  endfunction

  // A write acknowledgement carries zero data. A read returns the memory word.
  function automatic logic [DATA_W-1:0] resp_data(input logic            we,
                                                  input logic [DATA_W-1:0] rdata);
    logic [DATA_W-1:0] r;
    if (we) r = '0;
    else    r = rdata;
    return r;
  endfunction

  // Arbitration state
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Stage 1: memory command plus response tag
  logic              vld_p1_q,   vld_p1_d;
  logic              we_p1_q,    we_p1_d;
  logic              port_p1_q,  port_p1_d;
  logic [ADDR_W-1:0] addr_p1_q,  addr_p1_d;
  logic [DATA_W-1:0] wdata_p1_q, wdata_p1_d;

  // Stage 2: the tag waits here while the memory produces its read data
  logic              vld_p2_q,   vld_p2_d;
  logic              we_p2_q,    we_p2_d;
  logic              port_p2_q,  port_p2_d;

  // Stage 3: registered responses
  logic              rsp0_vld_p3_q,   rsp0_vld_p3_d;
  logic              rsp1_vld_p3_q,   rsp1_vld_p3_d;
  logic [DATA_W-1:0] rsp0_rdata_p3_q, rsp0_rdata_p3_d;
  logic [DATA_W-1:0] rsp1_rdata_p3_q, rsp1_rdata_p3_d;

  logic              gnt0, gnt1;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Grant: a lone requester wins. Under contention, port 1 wins until its burst
  // budget is used up. No grant is issued while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (arst_ni) begin
      if (req0_valid_i && req1_valid_i) begin
        if (cnt_q < CNT_MAX) gnt1 = 1'b1;
        else                 gnt0 = 1'b1;
      end else begin
        gnt0 = req0_valid_i;
        gnt1 = req1_valid_i;
      end
    end
  end

  // Request mux: selects the granted port's command fields.
  always_comb begin
    sel_we    = req0_we_i;
    sel_addr  = req0_addr_i;
    sel_wdata = req0_wdata_i;
    if (gnt1) begin
      sel_we    = req1_we_i;
      sel_addr  = req1_addr_i;
      sel_wdata = req1_wdata_i;
    end
  end

  // Next state for the burst counter and all three pipeline stages.
  always_comb begin
    // burst counter: port 0 clears it, port 1 counts up to saturation
    cnt_d = cnt_q;
    if (gnt0)      cnt_d = '0;
    else if (gnt1) cnt_d = sat_inc(cnt_q);

    // ---- stage 1: issue the accepted request to memory ----
    vld_p1_d   = gnt0 | gnt1;
    we_p1_d    = 1'b0;
    port_p1_d  = gnt1;
    addr_p1_d  = addr_p1_q;
    wdata_p1_d = wdata_p1_q;
    if (gnt0 | gnt1) begin
      we_p1_d    = sel_we;
      addr_p1_d  = sel_addr;
      wdata_p1_d = sel_wdata;
    end

    // ---- stage 2: align tag with memory read latency ----
    vld_p2_d  = vld_p1_q;
    we_p2_d   = we_p1_q;
    port_p2_d = port_p1_q;

    // ---- stage 3: capture read data and route to the tagged port ----
    rsp0_vld_p3_d   = vld_p2_q & ~port_p2_q;
    rsp1_vld_p3_d   = vld_p2_q &  port_p2_q;
    rsp0_rdata_p3_d = rsp0_rdata_p3_q;
    rsp1_rdata_p3_d = rsp1_rdata_p3_q;
    if (vld_p2_q && !port_p2_q) rsp0_rdata_p3_d = resp_data(we_p2_q, mem_rdata_i);
    if (vld_p2_q &&  port_p2_q) rsp1_rdata_p3_d = resp_data(we_p2_q, mem_rdata_i);
  end

  // State registers. Reset drops every in-flight access and clears the outputs.
  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      cnt_q           <= '0;
      vld_p1_q        <= 1'b0;
      we_p1_q         <= 1'b0;
      port_p1_q       <= 1'b0;
      addr_p1_q       <= '0;
      wdata_p1_q      <= '0;
      vld_p2_q        <= 1'b0;
      we_p2_q         <= 1'b0;
      port_p2_q       <= 1'b0;
      rsp0_vld_p3_q   <= 1'b0;
      rsp1_vld_p3_q   <= 1'b0;
      rsp0_rdata_p3_q <= '0;
      rsp1_rdata_p3_q <= '0;
    end else begin
      cnt_q           <= cnt_d;
      vld_p1_q        <= vld_p1_d;
      we_p1_q         <= we_p1_d;
      port_p1_q       <= port_p1_d;
      addr_p1_q       <= addr_p1_d;
      wdata_p1_q      <= wdata_p1_d;
      vld_p2_q        <= vld_p2_d;
      we_p2_q         <= we_p2_d;
      port_p2_q       <= port_p2_d;
      rsp0_vld_p3_q   <= rsp0_vld_p3_d;
      rsp1_vld_p3_q   <= rsp1_vld_p3_d;
      rsp0_rdata_p3_q <= rsp0_rdata_p3_d;
      rsp1_rdata_p3_q <= rsp1_rdata_p3_d;
    end
  end

  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;
  assign mem_en_o     = vld_p1_q;
  assign mem_we_o     = we_p1_q;
  assign mem_addr_o   = addr_p1_q;
  assign mem_wdata_o  = wdata_p1_q;
  assign rsp0_valid_o = rsp0_vld_p3_q;
  assign rsp1_valid_o = rsp1_vld_p3_q;
  assign rsp0_rdata_o = rsp0_rdata_p3_q;
  assign rsp1_rdata_o = rsp1_rdata_p3_q;
  assign grant_cnt_o  = cnt_q;

endmodule

// File: tb/tb_vga_native_arbiter.sv
// Testbench for vga_native_arbiter: memory model, cycle-level reference model
// and response scoreboard, plus directed scenarios.
module tb_vga_native_arbiter;
  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;
  localparam int CNT_W     = $clog2(MAX_BURST + 1);

  logic              clk_i = 1'b0;
  logic              arst_ni;
  logic              req0_valid_i, req0_ready_o, req0_we_i;
  logic [ADDR_W-1:0] req0_addr_i;
  logic [DATA_W-1:0] req0_wdata_i;
  logic              rsp0_valid_o;
  logic [DATA_W-1:0] rsp0_rdata_o;
  logic              req1_valid_i, req1_ready_o, req1_we_i;
  logic [ADDR_W-1:0] req1_addr_i;
  logic [DATA_W-1:0] req1_wdata_i;
  logic              rsp1_valid_o;
  logic [DATA_W-1:0] rsp1_rdata_o;
  logic              mem_en_o, mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i = '0;
  logic [CNT_W-1:0]  grant_cnt_o;

  vga_native_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_we_i(req0_we_i),
    .req0_addr_i(req0_addr_i), .req0_wdata_i(req0_wdata_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_rdata_o(rsp0_rdata_o),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_we_i(req1_we_i),
    .req1_addr_i(req1_addr_i), .req1_wdata_i(req1_wdata_i),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_rdata_o(rsp1_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .grant_cnt_o(grant_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic              port;
    logic [DATA_W-1:0] data;
  } rsp_t;

  rsp_t              sb[$];
  logic [DATA_W-1:0] mem     [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  // reference model state
  int                m_cnt   = 0;
  bit                m_v1    = 1'b0;
  bit                m_v2    = 1'b0;
  bit                m_v3    = 1'b0;
  logic              m_we1   = 1'b0;
  logic [ADDR_W-1:0] m_addr1 = '0;
  logic [DATA_W-1:0] m_wdat1 = '0;
  logic              mg0, mg1;
  rsp_t              mon_e;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // synchronous-read single-port memory
  always @(posedge clk_i) begin
    if (mem_en_o) begin
      if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
      else          mem_rdata_i     <= mem[mem_addr_o];
    end
  end

  // cycle monitor: check this cycle's outputs, then advance the model
  always @(negedge clk_i) begin
    if (mon_en) begin
      check("mem_en", 32'(mem_en_o), 32'(m_v1));
      if (m_v1) begin
        check("mem_we", 32'(mem_we_o), 32'(m_we1));
        check("mem_addr", 32'(mem_addr_o), 32'(m_addr1));
        if (m_we1) check("mem_wdata", mem_wdata_o, m_wdat1);
      end else begin
        check("mem_we_idle", 32'(mem_we_o), 32'd0);
      end
      if (m_v3 && sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("rsp0_valid", 32'(rsp0_valid_o), 32'(!mon_e.port));
        check("rsp1_valid", 32'(rsp1_valid_o), 32'(mon_e.port));
        if (mon_e.port) check("rsp1_rdata", rsp1_rdata_o, mon_e.data);
        else            check("rsp0_rdata", rsp0_rdata_o, mon_e.data);
      end else begin
        check("rsp0_idle", 32'(rsp0_valid_o), 32'd0);
        check("rsp1_idle", 32'(rsp1_valid_o), 32'd0);
      end

      mg0 = arst_ni && req0_valid_i && (!req1_valid_i || m_cnt >= MAX_BURST);
      mg1 = arst_ni && req1_valid_i && (!req0_valid_i || m_cnt <  MAX_BURST);
      check("ready0", 32'(req0_ready_o), 32'(mg0));
      check("ready1", 32'(req1_ready_o), 32'(mg1));
      check("grant_cnt", 32'(grant_cnt_o), 32'(m_cnt));

      if (!arst_ni) begin
        m_cnt = 0; m_v1 = 1'b0; m_v2 = 1'b0; m_v3 = 1'b0;
        sb.delete();
      end else begin
        m_v3 = m_v2;
        m_v2 = m_v1;
        m_v1 = mg0 || mg1;
        if (mg0 || mg1) begin
          m_we1   = mg1 ? req1_we_i    : req0_we_i;
          m_addr1 = mg1 ? req1_addr_i  : req0_addr_i;
          m_wdat1 = mg1 ? req1_wdata_i : req0_wdata_i;
          mon_e.port = mg1;
          mon_e.data = m_we1 ? '0 : ref_mem[m_addr1];
          if (m_we1) ref_mem[m_addr1] = m_wdat1;
          sb.push_back(mon_e);
        end
        if (mg0)                           m_cnt = 0;
        else if (mg1 && m_cnt < MAX_BURST) m_cnt++;
      end
    end
  end

  task automatic step(input logic v0, input logic w0, input logic [ADDR_W-1:0] a0,
                      input logic [DATA_W-1:0] d0,
                      input logic v1, input logic w1, input logic [ADDR_W-1:0] a1,
                      input logic [DATA_W-1:0] d1);
    @(posedge clk_i); #1;
    req0_valid_i = v0; req0_we_i = w0; req0_addr_i = a0; req0_wdata_i = d0;
    req1_valid_i = v1; req1_we_i = w1; req1_addr_i = a1; req1_wdata_i = d1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  logic [14:0] burst_seq;
  int          cnt_seq [15];

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      mem[i]     = 32'(i) * 32'h9E3779B1;
      ref_mem[i] = 32'(i) * 32'h9E3779B1;
    end
    mem[12'h010]     = 32'hDEADBEEF;
    ref_mem[12'h010] = 32'hDEADBEEF;
    burst_seq = 15'b111101111011110;  // MSB = first cycle
    cnt_seq   = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0};

    // reset with both requesters valid
    arst_ni = 1'b0;
    req0_valid_i = 1'b1; req0_we_i = 1'b0; req0_addr_i = 12'h100; req0_wdata_i = '0;
    req1_valid_i = 1'b1; req1_we_i = 1'b0; req1_addr_i = 12'h200; req1_wdata_i = '0;
    @(posedge clk_i); #1; mon_en = 1'b1;
    @(posedge clk_i); @(posedge clk_i); #2;
    check("rst_ready0", 32'(req0_ready_o), 32'd0);
    check("rst_ready1", 32'(req1_ready_o), 32'd0);
    check("rst_mem_en", 32'(mem_en_o), 32'd0);
    check("rst_rsp0", 32'(rsp0_valid_o), 32'd0);
    check("rst_rsp1", 32'(rsp1_valid_o), 32'd0);
    check("rst_addr", 32'(mem_addr_o), 32'd0);
    check("rst_wdata", mem_wdata_o, 32'd0);
    check("rst_rdata0", rsp0_rdata_o, 32'd0);
    check("rst_rdata1", rsp1_rdata_o, 32'd0);
    check("rst_cnt", 32'(grant_cnt_o), 32'd0);

    // release: port 1 wins the first contested cycle
    @(posedge clk_i); #1; arst_ni = 1'b1; #1;
    check("rel_ready1", 32'(req1_ready_o), 32'd1);
    check("rel_ready0", 32'(req0_ready_o), 32'd0);

    // port 1 write
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'h0FF, 32'hA5A5A5A5);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0); #1;
    check("wr_mem_we", 32'(mem_we_o), 32'd1);
    check("wr_mem_addr", 32'(mem_addr_o), 32'h0FF);
    check("wr_mem_wdata", mem_wdata_o, 32'hA5A5A5A5);
    idle(2); #1;
    check("wr_rsp1_valid", 32'(rsp1_valid_o), 32'd1);
    check("wr_rsp1_rdata", rsp1_rdata_o, 32'd0);
    idle(2);

    // port 0 read
    step(1'b1, 1'b0, 12'h010, '0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0); #1;
    check("rd_mem_en", 32'(mem_en_o), 32'd1);
    check("rd_mem_addr", 32'(mem_addr_o), 32'h010);
    idle(2); #1;
    check("rd_rsp0_valid", 32'(rsp0_valid_o), 32'd1);
    check("rd_rsp0_rdata", rsp0_rdata_o, 32'hDEADBEEF);
    check("rd_rsp1_quiet", 32'(rsp1_valid_o), 32'd0);
    idle(3);

    // contention: both valid for 15 cycles, random reads/writes
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'($urandom), ADDR_W'($urandom), $urandom,
           1'b1, 1'($urandom), ADDR_W'($urandom), $urandom);
      #1;
      check("burst_gnt1", 32'(req1_ready_o), 32'(burst_seq[14-i]));
      if (i > 0) check("burst_cnt", 32'(grant_cnt_o), 32'(cnt_seq[i-1]));
    end
    idle(5);

    // port 1 alone: counter saturates, then port 0 wins at once
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b0, '0, '0, 1'b1, 1'($urandom), ADDR_W'($urandom), $urandom);
    step(1'b1, 1'b0, 12'h055, '0, 1'b1, 1'b0, 12'h066, '0); #1;
    check("sat_cnt", 32'(grant_cnt_o), 32'(MAX_BURST));
    check("sat_ready0", 32'(req0_ready_o), 32'd1);
    check("sat_ready1", 32'(req1_ready_o), 32'd0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h066, '0); #1;
    check("sat_cnt_clr", 32'(grant_cnt_o), 32'd0);
    check("sat_ready1_next", 32'(req1_ready_o), 32'd1);
    idle(5);

    // reset with two reads in flight
    step(1'b1, 1'b0, 12'h020, '0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h030, '0);
    step(1'b1, 1'b0, 12'h040, '0, 1'b0, 1'b0, '0, '0);
    arst_ni = 1'b0; #1;
    check("mf_ready0_in_rst", 32'(req0_ready_o), 32'd0);
    check("mf_mem_en_pre", 32'(mem_en_o), 32'd1);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    arst_ni = 1'b1; #1;
    check("mf_mem_en_post", 32'(mem_en_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("mf_rsp0_quiet", 32'(rsp0_valid_o), 32'd0);
      check("mf_rsp1_quiet", 32'(rsp1_valid_o), 32'd0);
      idle(1); #1;
    end

    idle(5); #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
